// File: rtl/enc_gen.sv
// Purpose: systematic extended-Hamming encoder, modes (8,4)/(16,11)/(32,26), with optional error injection.
// Latency: 2 registered stages; a word accepted at edge N is presented on data_out after edge N+1.
// Backpressure: valid/ready; in_ready = !s1_valid || s2_free, so it sustains 1 word/cycle and stalls cleanly.
module enc_gen #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    work_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_WIDTH-1:0]          word_count,
    output logic                          mod_err
);

    localparam int MAX_PARITY_WIDTH = 6;

    // Stage 1 holding registers
    logic                          s1_valid;
    logic [MAX_INFO_WIDTH-1:0]     s1_data;
    logic [1:0]                    s1_mod;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_mask;

    // Encoder datapath between S1 and S2
    logic [MAX_CODEWORD_WIDTH-1:0] info_sh;
    logic [MAX_CODEWORD_WIDTH-1:0] len_mask;
    logic [MAX_CODEWORD_WIDTH-1:0] enc_cw;
    logic [MAX_CODEWORD_WIDTH-1:0] s2_next;
    logic [MAX_PARITY_WIDTH-1:0]   par;
    logic                          legal;

    logic s2_free;
    logic accept;
    logic advance;
    logic deliver;

    assign s2_free = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid && s2_free;
    assign deliver  = out_valid && out_ready;

    // Place info bits above the parity field, compute parity per mode, and build the injected codeword.
    // Parity bits of info_sh are zero, so masking a full H row against it only picks up info positions.
    always_comb begin
        info_sh  = '0;
        len_mask = '0;
        par      = '0;
        legal    = 1'b1;
        case (s1_mod)
            2'b00: begin
                info_sh  = {24'b0, s1_data[3:0], 4'b0};
                len_mask = 32'h0000_00FF;
                par[0]   = ^(info_sh & 32'h0000_00B1);
                par[1]   = ^(info_sh & 32'h0000_00D2);
                par[2]   = ^(info_sh & 32'h0000_00E4);
                par[3]   = (^info_sh) ^ par[0] ^ par[1] ^ par[2];
            end
            2'b01: begin
                info_sh  = {16'b0, s1_data[10:0], 5'b0};
                len_mask = 32'h0000_FFFF;
                par[0]   = ^(info_sh & 32'h0000_AB61);
                par[1]   = ^(info_sh & 32'h0000_CDA2);
                par[2]   = ^(info_sh & 32'h0000_F1C4);
                par[3]   = ^(info_sh & 32'h0000_FE08);
                par[4]   = (^info_sh) ^ par[0] ^ par[1] ^ par[2] ^ par[3];
            end
            2'b10: begin
                info_sh  = {s1_data[25:0], 6'b0};
                len_mask = 32'hFFFF_FFFF;
                par[0]   = ^(info_sh & 32'hAAAB_56C1);
                par[1]   = ^(info_sh & 32'hCCCD_9B42);
                par[2]   = ^(info_sh & 32'hF0F1_E384);
                par[3]   = ^(info_sh & 32'hFF01_FC08);
                par[4]   = ^(info_sh & 32'hFFFE_0010);
                par[5]   = (^info_sh) ^ par[0] ^ par[1] ^ par[2] ^ par[3] ^ par[4];
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        enc_cw  = info_sh | {26'b0, par};
        s2_next = enc_cw ^ (s1_mask & len_mask);
    end

    // S1: capture a word on accept, empty when it moves on to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mod   <= '0;
            s1_mask  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= data_in;
            s1_mod   <= work_mod;
            s1_mask  <= inj_mask;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: take encoded word from S1 (illegal-mode words are dropped here), hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (advance) begin
            out_valid <= legal;
            if (legal) begin
                data_out <= s2_next;
            end
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-word counter (wraps) and sticky illegal-mode flag
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            mod_err    <= 1'b0;
        end else begin
            if (deliver) begin
                word_count <= word_count + 1'b1;
            end
            if (advance && !legal) begin
                mod_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enc_gen.sv
// Directed bench for enc_gen: reset state, codewords per mode, injection, throughput,
// backpressure, illegal mode and mid-flight reset. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_enc_gen;

    logic        clk;
    logic        rst;
    logic [25:0] data_in;
    logic [1:0]  work_mod;
    logic [31:0] inj_mask;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;
    logic        mod_err;

    int n_chk  = 0;
    int n_fail = 0;

    enc_gen #(
        .MAX_CODEWORD_WIDTH(32),
        .MAX_INFO_WIDTH(26),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .work_mod(work_mod),
        .inj_mask(inj_mask),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out(data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_count(word_count),
        .mod_err(mod_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one word with out_ready high and wait (bounded) for its codeword.
    task automatic xfer(input logic [1:0] m, input logic [25:0] d, input logic [31:0] mk,
                        input logic [31:0] exp, input string tag);
        logic [31:0] got;
        logic        seen;
        work_mod = m;
        data_in  = d;
        inj_mask = mk;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        inj_mask = '0;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                got  = data_out;
            end
            step();
        end
        chk({tag, " out_valid seen"}, {31'b0, seen}, 32'h1);
        chk(tag, got, exp);
    endtask

    logic [15:0] wc0;
    logic [31:0] held;
    logic [31:0] got_q[$];
    logic        any_vld;
    int          acc;
    logic [25:0] bp_words[4];

    initial begin
        rst       = 1'b1;
        data_in   = '0;
        work_mod  = 2'b00;
        inj_mask  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset data_out", data_out, 32'h0);
        chk("reset word_count", {16'b0, word_count}, 32'h0);
        chk("reset mod_err", {31'b0, mod_err}, 32'h0);
        chk("reset in_ready", {31'b0, in_ready}, 32'h1);

        // Codeword values across modes
        out_ready = 1'b1;
        xfer(2'b00, 26'h1,       32'h0,         32'h0000_001B, "m00 d1");
        xfer(2'b00, 26'hF,       32'h0,         32'h0000_00FF, "m00 dF");
        xfer(2'b01, 26'h7FF,     32'h0,         32'h0000_FFFF, "m01 d7FF");
        xfer(2'b10, 26'h3FFFFFF, 32'h0,         32'hFFFF_FFFF, "m10 all ones");
        xfer(2'b01, 26'h0,       32'h0,         32'h0000_0000, "m01 d0");
        xfer(2'b01, 26'h1,       32'h0,         32'h0000_0033, "m01 d1");
        xfer(2'b00, 26'h3FFFFF1, 32'h0,         32'h0000_001B, "m00 upper info ignored");
        xfer(2'b00, 26'h1,       32'h0000_0110, 32'h0000_000B, "m00 inject bit8 dropped");
        chk("word_count after 8", {16'b0, word_count}, 32'd8);

        // Throughput: three back-to-back words, one cycle latency after accept edge
        wc0 = word_count;
        work_mod = 2'b00;
        data_in  = 26'h1;
        in_valid = 1'b1;
        chk("tp in_ready w1", {31'b0, in_ready}, 32'h1);
        step();
        chk("tp out_valid not yet", {31'b0, out_valid}, 32'h0);
        chk("tp in_ready w2", {31'b0, in_ready}, 32'h1);
        data_in = 26'h2;
        step();
        chk("tp out_valid 1", {31'b0, out_valid}, 32'h1);
        chk("tp data 1", data_out, 32'h0000_001B);
        chk("tp in_ready w3", {31'b0, in_ready}, 32'h1);
        data_in = 26'h3;
        step();
        in_valid = 1'b0;
        chk("tp out_valid 2", {31'b0, out_valid}, 32'h1);
        chk("tp data 2", data_out, 32'h0000_002D);
        step();
        chk("tp out_valid 3", {31'b0, out_valid}, 32'h1);
        chk("tp data 3", data_out, 32'h0000_0036);
        step();
        chk("tp drained", {31'b0, out_valid}, 32'h0);
        chk("tp word_count +3", {16'b0, word_count}, {16'b0, wc0 + 16'd3});

        // Backpressure: out_ready low for 5 cycles with in_valid held high
        bp_words[0] = 26'h4;
        bp_words[1] = 26'h5;
        bp_words[2] = 26'h6;
        bp_words[3] = 26'h7;
        out_ready = 1'b0;
        acc = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            data_in  = bp_words[acc];
            in_valid = 1'b1;
            if (c == 2) held = data_out;
            if (c >= 2) begin
                chk("bp out_valid held", {31'b0, out_valid}, 32'h1);
                chk("bp data stable", data_out, 32'h0000_004E);
            end
            if (in_ready) acc++;
            step();
        end
        chk("bp accepts", acc, 32'd2);
        chk("bp in_ready low", {31'b0, in_ready}, 32'h0);
        chk("bp data unchanged", data_out, held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 6; c++) begin
            if (out_valid) got_q.push_back(data_out);
            step();
        end
        chk("bp release count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            chk("bp release w0", got_q[0], 32'h0000_004E);
            chk("bp release w1", got_q[1], 32'h0000_0055);
        end

        // Illegal mode: accepted, produces nothing, sets sticky mod_err
        wc0 = word_count;
        work_mod = 2'b11;
        data_in  = 26'h1;
        in_valid = 1'b1;
        chk("ill in_ready", {31'b0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        any_vld  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) any_vld = 1'b1;
            step();
        end
        chk("ill no output", {31'b0, any_vld}, 32'h0);
        chk("ill mod_err set", {31'b0, mod_err}, 32'h1);
        chk("ill word_count same", {16'b0, word_count}, {16'b0, wc0});
        xfer(2'b00, 26'h2, 32'h0, 32'h0000_002D, "after illegal");
        chk("mod_err sticky", {31'b0, mod_err}, 32'h1);

        // Reset with words in S1 and S2
        out_ready = 1'b0;
        work_mod  = 2'b00;
        data_in   = 26'h9;
        in_valid  = 1'b1;
        step();
        data_in = 26'hA;
        step();
        in_valid = 1'b0;
        chk("pre-rst out_valid", {31'b0, out_valid}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst word_count", {16'b0, word_count}, 32'h0);
        chk("rst mod_err", {31'b0, mod_err}, 32'h0);
        chk("rst in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        any_vld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) any_vld = 1'b1;
            step();
        end
        chk("rst no stale word", {31'b0, any_vld}, 32'h0);
        chk("rst word_count still 0", {16'b0, word_count}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
